// File: rtl/signed_bcd_converter_if.sv
// Handshake and result bus for the signed binary-to-BCD converter.
interface signed_bcd_converter_if;
  logic       start;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       neg;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  modport master (
    output start, din,
    input  busy, done, neg, hundreds, tens, ones
  );

  modport slave (
    input  start, din,
    output busy, done, neg, hundreds, tens, ones
  );
endinterface

// File: rtl/signed_bcd_converter.sv
// Signed 8-bit to sign + 3-digit BCD converter using the shift-and-add-3 (double dabble) method.
// One conversion takes 8 shift cycles; results are held until the next completion.
module signed_bcd_converter (
  input  logic                          clk,
  input  logic                          rst_n,
  signed_bcd_converter_if.slave         bus
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] scratch_q, scratch_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        neg_q, neg_d;
  logic [11:0] digits_q, digits_d;
  logic        done_q, done_d;

  logic        accept;
  logic        last_shift;
  logic [11:0] adj;
  logic [19:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign accept     = (state_q == StIdle) && bus.start;
  assign last_shift = (state_q == StShift) && (cnt_q == 3'd7);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StShift;
      StShift: if (cnt_q == 3'd7) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: digits are corrected before the joint left shift
  always_comb begin
    adj       = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    shifted   = {adj, mag_q} << 1;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    neg_d     = neg_q;
    digits_d  = digits_q;
    done_d    = 1'b0;
    if (accept) begin
      sign_d    = bus.din[7];
      // 8-bit unsigned negate: -128 maps cleanly to 128
      mag_d     = bus.din[7] ? (~bus.din + 8'd1) : bus.din;
      scratch_d = '0;
      cnt_d     = '0;
    end else if (state_q == StShift) begin
      scratch_d = shifted[19:8];
      mag_d     = shifted[7:0];
      cnt_d     = cnt_q + 3'd1;
      if (last_shift) begin
        digits_d = shifted[19:8];
        neg_d    = sign_q;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      neg_q     <= 1'b0;
      digits_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      neg_q     <= neg_d;
      digits_q  <= digits_d;
      done_q    <= done_d;
    end
  end

  // Outputs
  always_comb begin
    bus.busy     = (state_q == StShift);
    bus.done     = done_q;
    bus.neg      = neg_q;
    bus.hundreds = digits_q[11:8];
    bus.tens     = digits_q[7:4];
    bus.ones     = digits_q[3:0];
  end

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Scoreboard bench for signed_bcd_converter: reference results queued at acceptance,
// compared when done pulses; holding, latency, busy and reset behaviour are checked too.
module tb_signed_bcd_converter;

  logic clk;
  logic rst_n;

  signed_bcd_converter_if bus ();

  signed_bcd_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [12:0] exp_q[$];
  logic [12:0] held;
  logic        prev_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [12:0] ref_bcd(input logic [7:0] v);
    int s;
    int m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    return {(s < 0), 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [12:0] dut_res();
    return {bus.neg, bus.hundreds, bus.tens, bus.ones};
  endfunction

  // Monitor: compares results at done, and checks outputs do not move mid-conversion
  initial begin
    held      = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held      = '0;
        prev_done = 1'b0;
      end else begin
        if (bus.done) begin
          check_eq("done_width", prev_done, 1'b0);
          if (exp_q.size() == 0) begin
            check_eq("unexpected_done", bus.done, 1'b0);
          end else begin
            held = exp_q.pop_front();
            check_eq("result", dut_res(), held);
          end
        end else if (bus.busy) begin
          check_eq("hold_mid_conv", dut_res(), held);
        end
        prev_done = bus.done;
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the completion edge (done cycle)
  task automatic run_conv(input logic [7:0] v);
    bus.din   = v;
    bus.start = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_bcd(v));
    #1;
    bus.start = 1'b0;
    bus.din   = 8'($urandom);
    check_eq("busy_after_accept", bus.busy, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    check_eq("busy_before_done", bus.busy, 1'b1);
    check_eq("done_early", bus.done, 1'b0);
    @(posedge clk);
    #1;
    check_eq("done_latency", bus.done, 1'b1);
    check_eq("busy_in_done", bus.busy, 1'b0);
  endtask

  logic [7:0] vec[5];

  initial begin
    vec = '{8'd0, 8'd127, 8'h80, 8'hFF, 8'd10};
    bus.start = 1'b0;
    bus.din   = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", bus.busy, 1'b0);
    check_eq("reset_done", bus.done, 1'b0);
    check_eq("reset_result", dut_res(), 13'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner values
    foreach (vec[i]) begin
      run_conv(vec[i]);
      repeat (2) @(posedge clk);
      #1;
    end

    // Second start while busy must be ignored
    bus.din   = 8'hD3;  // -45
    bus.start = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_bcd(8'hD3));
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.din   = 8'd99;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("ignored_start_done", bus.done, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    check_eq("ignored_start_idle", bus.busy, 1'b0);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back: second start issued in the done cycle
    run_conv(8'd64);
    run_conv(8'hF7);  // -9
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-conversion
    bus.din   = 8'd100;
    bus.start = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_bcd(8'd100));
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_result", dut_res(), 13'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("rst_no_done", bus.done, 1'b0);
    check_eq("rst_held_zero", dut_res(), 13'd0);
    run_conv(8'd100);
    repeat (2) @(posedge clk);
    #1;

    // Exhaustive back-to-back sweep
    for (int i = -128; i < 128; i++) begin
      run_conv(8'(i));
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the bench always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/signed_bcd_converter.md
SIGNED_BCD_CONVERTER -- requirements
Module: signed_bcd_converter

Interface
REQ-001 Parameters SHALL be none; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to convert din, sampled on the rising clk edge.
REQ-005 din  input  8  signed two's-complement value (counter output, range -128..127).
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  single-cycle pulse marking valid new result.
REQ-008 neg  output  1  sign of last converted value, 1 = negative.
REQ-009 hundreds  output  4  BCD hundreds digit of |din|, range 0..1.
REQ-010 tens  output  4  BCD tens digit of |din|, range 0..9.
REQ-011 ones  output  4  BCD ones digit of |din|, range 0..9.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-013 In IDLE with start=1 at edge k: latch neg=din[7], latch 8-bit unsigned magnitude |din|, clear 12-bit BCD scratch, set bit counter to 0, enter SHIFT.
REQ-014 Magnitude SHALL be computed in 8 bits unsigned so -128 yields 128 without overflow.
REQ-015 neg SHALL be 0 for din=0; no negative zero.
REQ-016 In SHIFT, each edge: any scratch digit >=5 gets +3 (all three digits checked in parallel), then {scratch,mag} shifts left by 1; counter increments.
REQ-017 Exactly 8 shift iterations SHALL occur, at edges k+1..k+8.
REQ-018 At edge k+8 (counter=7): hundreds/tens/ones SHALL load the post-shift scratch digits, done SHALL go high for one cycle, FSM returns to IDLE.
REQ-019 Latency: start sampled at edge k -> results and done valid in the cycle after edge k+8.
REQ-020 busy SHALL be high for the cycles after edges k..k+7 and low in the done cycle.
REQ-021 start while busy=1 SHALL be ignored; no queuing, no effect on the running conversion.
REQ-022 start in the done cycle (FSM in IDLE) SHALL be accepted; back-to-back conversions every 9 cycles.
REQ-023 hundreds/tens/ones/neg SHALL hold their last result until the next completion; they SHALL NOT change mid-conversion.
REQ-024 neg output SHALL update only at completion, together with the digits.
REQ-025 done SHALL never be high for two consecutive cycles.
REQ-026 din SHALL be sampled only at the accepting edge; later din changes do not affect the result.

Reset
REQ-027 rst_n=0 SHALL immediately, without clk, force IDLE, busy=0, done=0, neg=0, hundreds=tens=ones=0, counter=0, scratch=0.
REQ-028 Reset asserted mid-conversion SHALL abort it; no done pulse, outputs read 0.
REQ-029 After rst_n deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-030 din=0, start pulse -> 8 cycles later done=1, neg=0, digits 0/0/0.
REQ-031 din=127 -> neg=0, 1/2/7; din=-128 (0x80) -> neg=1, 1/2/8; din=-1 (0xFF) -> neg=1, 0/0/1.
REQ-032 din=-45, start; change din to 99 and pulse start at cycle 3 -> single done, neg=1, 0/4/5; second start ignored.
REQ-033 din=64 start, then din=-9 start in the done cycle -> first done 0/6/4 neg=0, second done 9 cycles later 0/0/9 neg=1.
REQ-034 Start din=100, drop rst_n at cycle 4 -> busy, done, all digits 0 immediately; no done pulse; start after release converts normally.
REQ-035 Exhaustive sweep din=-128..127 -> each result matches reference sign/magnitude decimal, done width exactly 1 cycle.
